// File: rtl/cpu_uart_pkg.sv
// rtl/cpu_uart_pkg.sv - shared types and constants for the CPU UART blocks
package cpu_uart_pkg;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } utx_state_e;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_WORD_W               = 16;

endpackage

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - synchronous word FIFO with registered full and level
module uart_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    // A push while full is refused even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/uart_result_tx.sv
// rtl/uart_result_tx.sv - queues 16-bit result words and sends each as two 8N1 frames
module uart_result_tx
    import cpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          word_valid,
    input  logic [UART_WORD_W-1:0]        word_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    utx_state_e             state_q, state_d;
    logic [UART_WORD_W-1:0] shreg_q, shreg_d;
    logic                   byte_sel_q, byte_sel_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic                   tx_q, tx_d;
    logic                   overflow_q, overflow_d;

    logic                   pop;
    logic                   fifo_empty;
    logic [UART_WORD_W-1:0] fifo_rd_data;
    logic [7:0]             cur_byte;
    logic                   baud_done;

    uart_word_fifo #(
        .WIDTH (UART_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (word_valid),
        .pop     (pop),
        .wr_data (word_data),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // High byte goes out first.
    assign cur_byte  = byte_sel_q ? shreg_q[7:0] : shreg_q[15:8];
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_sel_d = byte_sel_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (word_valid & full);

        case (state_q)
            UTX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = fifo_rd_data;
                    byte_sel_d = 1'b0;
                    baud_d     = '0;
                    state_d    = UTX_START;
                    tx_d       = 1'b0;
                end
            end
            UTX_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = UTX_DATA;
                    tx_d      = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UTX_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UTX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UTX_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = UTX_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = UTX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = UTX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= UTX_IDLE;
            shreg_q    <= '0;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_sel_q <= byte_sel_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != UTX_IDLE);
    assign tx       = tx_q;
    assign overflow = overflow_q;

endmodule
